// File: rtl/mem_sum_engine.sv
// Array-sum engine: reads len elements two per cycle from a dual-read memory,
// accumulates them modulo 2^n and writes the total back to dst_addr.
module mem_sum_engine #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] src_addr,
    input  logic [N-1:0] len,
    input  logic [N-1:0] dst_addr,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic [N-1:0] mem_rd0_addr,
    output logic [N-1:0] mem_rd1_addr,
    input  logic [N-1:0] mem_rd0_data,
    input  logic [N-1:0] mem_rd1_data,
    output logic [N-1:0] mem_wr_addr,
    output logic [N-1:0] mem_wr_data,
    output logic         mem_wr_en
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] ptr;
    logic [N-1:0] remaining;
    logic [N-1:0] acc;
    logic [N-1:0] dst;
    logic [N-1:0] rem_nx;
    logic         pair;

    assign pair   = (remaining >= N'(2));
    assign rem_nx = pair ? remaining - N'(2) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_rd0_addr = '0;
        mem_rd1_addr = '0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        mem_wr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? READ : WRITE;
                end
            end
            READ: begin
                busy         = 1'b1;
                mem_rd0_addr = ptr;
                mem_rd1_addr = ptr + N'(1);
                if (rem_nx == '0) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_addr = dst;
                mem_wr_data = acc;
                state_nx    = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // An odd trailing element uses read port 0 only; port 1 data is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            acc       <= '0;
            dst       <= '0;
            sum       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= src_addr;
                        remaining <= len;
                        dst       <= dst_addr;
                        acc       <= '0;
                        sum       <= '0;
                    end
                end
                READ: begin
                    remaining <= rem_nx;
                    if (pair) begin
                        acc <= acc + mem_rd0_data + mem_rd1_data;
                        ptr <= ptr + N'(2);
                    end else begin
                        acc <= acc + mem_rd0_data;
                    end
                end
                WRITE: begin
                    sum <= acc;
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule
